// File: rtl/spi_slave.sv
// SPI responder. SCK, SS and MOSI are oversampled on the system clock; the
// design never clocks on SCK. A single-word TX holding buffer feeds the TX
// shift register at every word start, and each completed RX word is
// presented on data_out with a one-cycle valid_out strobe. Words run back to
// back for as long as SS stays low.
module spi_slave #(
  parameter int DATA_BITS = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b1,
  parameter bit LSBF      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SCK,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_oe,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic                 tx_underrun,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Synchronizer chains: bits [1:0] are the 2-FF synchronizer, bit [2] is
  // the previous synchronized value used for edge detection.
  logic [2:0] sck_q;
  logic [2:0] ss_q;
  logic [1:0] mosi_q;

  logic [DATA_BITS-1:0] tx_buf_q, tx_buf_d;
  logic                 tx_ready_q, tx_ready_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 underrun_q, underrun_d;

  logic                 sck_chg;
  logic                 lead_edge;
  logic                 trail_edge;
  logic                 sample_edge;
  logic                 shift_edge;
  logic                 ss_fall;
  logic                 ss_rise;
  logic                 word_end;
  logic                 mosi_s;
  logic [DATA_BITS-1:0] rx_next;
  logic [DATA_BITS-1:0] tx_next;
  logic                 xfer;

  // Oversample the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= {3{CPOL}};
      ss_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], SCK};
      ss_q   <= {ss_q[1:0], SS};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sck_chg     = sck_q[1] ^ sck_q[2];
  assign lead_edge   = sck_chg && (sck_q[2] == CPOL);
  assign trail_edge  = sck_chg && (sck_q[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ss_fall     = ss_q[2] & ~ss_q[1];
  assign ss_rise     = ~ss_q[2] & ss_q[1];
  assign mosi_s      = mosi_q[1];

  // The trailing edge of the last bit closes a word. With CPHA=0 the last
  // sample already wrapped bit_cnt to zero; with CPHA=1 the closing edge is
  // itself the last sample, so bit_cnt still holds the last index.
  assign word_end = trail_edge &&
                    (CPHA ? (bit_cnt_q == LAST_BIT) : (bit_cnt_q == '0));

  assign rx_next = LSBF ? {mosi_s, rx_sh_q[DATA_BITS-1:1]}
                        : {rx_sh_q[DATA_BITS-2:0], mosi_s};
  assign tx_next = LSBF ? {1'b0, tx_sh_q[DATA_BITS-1:1]}
                        : {tx_sh_q[DATA_BITS-2:0], 1'b0};

  // Next-state logic for the frame FSM, shift registers and TX buffer.
  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = bit_cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    xfer       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (ss_fall) begin
          xfer    = 1'b1;
          rx_sh_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          // Abandon any partial word; the holding buffer is left untouched.
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          if (sample_edge) begin
            rx_sh_d = rx_next;
            if (bit_cnt_q == LAST_BIT) begin
              data_out_d = rx_next;
              valid_d    = 1'b1;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // With CPHA=1 bit 0 is already on MISO, so its leading edge must
          // not shift.
          if (word_end) begin
            xfer = 1'b1;
          end else if (shift_edge && !(CPHA && (bit_cnt_q == '0))) begin
            tx_sh_d = tx_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A transfer takes the buffer as it stood this cycle; a same-cycle load
    // only lands if the buffer was already empty.
    if (xfer) begin
      if (!tx_ready_q) begin
        tx_sh_d    = tx_buf_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_sh_d    = '0;
        underrun_d = 1'b1;
      end
    end
    if (tx_load && tx_ready_q) begin
      tx_buf_d   = data_in;
      tx_ready_d = 1'b0;
    end
  end

  // State, datapath and strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_buf_q   <= '0;
      tx_ready_q <= 1'b1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign busy        = (state_q == ST_SHIFT);
  assign MISO_oe     = busy;
  assign MISO        = busy & (LSBF ? tx_sh_q[0] : tx_sh_q[DATA_BITS-1]);
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = underrun_q;
  assign data_out    = data_out_q;
  assign valid_out   = valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: two instances (A: CPOL=0 CPHA=1 MSB first,
// B: CPOL=1 CPHA=0 LSB first) share SCK/MOSI and have their own SS. A
// bit-banged master drives frames; expectations come from the words the
// bench chose to send and to load.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         SCK;
  logic         MOSI;
  logic         ss          [2];
  logic         miso        [2];
  logic         miso_oe     [2];
  logic [W-1:0] data_in     [2];
  logic         tx_load     [2];
  logic         tx_ready    [2];
  logic         tx_underrun [2];
  logic [W-1:0] data_out    [2];
  logic         valid_out   [2];
  logic         busy        [2];

  always #5 clk = ~clk;

  spi_slave #(.DATA_BITS(W), .CPOL(1'b0), .CPHA(1'b1), .LSBF(1'b0)) u_a (
    .clk(clk), .rst(rst), .SCK(SCK), .SS(ss[0]), .MOSI(MOSI),
    .MISO(miso[0]), .MISO_oe(miso_oe[0]), .data_in(data_in[0]),
    .tx_load(tx_load[0]), .tx_ready(tx_ready[0]), .tx_underrun(tx_underrun[0]),
    .data_out(data_out[0]), .valid_out(valid_out[0]), .busy(busy[0])
  );

  spi_slave #(.DATA_BITS(W), .CPOL(1'b1), .CPHA(1'b0), .LSBF(1'b1)) u_b (
    .clk(clk), .rst(rst), .SCK(SCK), .SS(ss[1]), .MOSI(MOSI),
    .MISO(miso[1]), .MISO_oe(miso_oe[1]), .data_in(data_in[1]),
    .tx_load(tx_load[1]), .tx_ready(tx_ready[1]), .tx_underrun(tx_underrun[1]),
    .data_out(data_out[1]), .valid_out(valid_out[1]), .busy(busy[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Frame description consumed by run_frame.
  logic [W-1:0] f_mosi [4];
  logic [W-1:0] f_tx   [4];
  bit           f_ld   [4];

  // Observer of the selected instance's strobes.
  int           cur_sel = 0;
  logic [W-1:0] rxq[$];
  int           und_cnt = 0;
  int           stray   = 0;

  always @(negedge clk) begin
    if (valid_out[cur_sel] === 1'b1) rxq.push_back(data_out[cur_sel]);
    if (tx_underrun[cur_sel] === 1'b1) und_cnt++;
    if (valid_out[1-cur_sel] === 1'b1 || tx_underrun[1-cur_sel] === 1'b1) stray++;
  end

  task automatic do_load(input int sel, input logic [W-1:0] v);
    data_in[sel] = v;
    tx_load[sel] = 1'b1;
    @(negedge clk);
    tx_load[sel] = 1'b0;
  endtask

  task automatic half_wait(input int sel, input bit ld, input logic [W-1:0] v);
    if (ld) begin
      check_eq("tx_ready_before_reload", tx_ready[sel], 1);
      do_load(sel, v);
      repeat (HALF-1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input int sel);
    check_eq("rst_miso", miso[sel], 0);
    check_eq("rst_miso_oe", miso_oe[sel], 0);
    check_eq("rst_tx_ready", tx_ready[sel], 1);
    check_eq("rst_tx_underrun", tx_underrun[sel], 0);
    check_eq("rst_data_out", data_out[sel], 0);
    check_eq("rst_valid_out", valid_out[sel], 0);
    check_eq("rst_busy", busy[sel], 0);
  endtask

  // n words; stop_bits>=0 aborts word 0 after that many bits (by SS or by rst).
  task automatic run_frame(input int sel, input int n, input int stop_bits, input bit use_rst);
    bit           cpol, cpha, lsbf, aborted, ld_now;
    logic [W-1:0] got [4];
    int           bi, exp_und;
    cpol = (sel == 1);
    cpha = (sel == 0);
    lsbf = (sel == 1);
    cur_sel = sel;
    rxq.delete();
    und_cnt = 0;
    stray   = 0;
    aborted = 1'b0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    SCK   = cpol;
    ss[0] = 1'b1;
    ss[1] = 1'b1;
    repeat (HALF) @(negedge clk);
    if (f_ld[0]) begin
      check_eq("tx_ready_idle", tx_ready[sel], 1);
      do_load(sel, f_tx[0]);
      check_eq("tx_ready_full", tx_ready[sel], 0);
      do_load(sel, ~f_tx[0]);
    end
    repeat (HALF) @(negedge clk);
    ss[sel] = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("busy_after_ss_fall", busy[sel], 1);
    check_eq("oe_after_ss_fall", miso_oe[sel], 1);
    check_eq("tx_ready_after_ss_fall", tx_ready[sel], 1);
    repeat (HALF-5) @(negedge clk);
    for (int w = 0; w < n && !aborted; w++) begin
      for (int b = 0; b < W; b++) begin
        if (stop_bits >= 0 && b == stop_bits) begin
          aborted = 1'b1;
          break;
        end
        bi = lsbf ? b : W-1-b;
        ld_now = (b == 2) && (w + 1 < n) && f_ld[w+1];
        if (!cpha) begin
          MOSI = f_mosi[w][bi];
          half_wait(sel, 1'b0, '0);
          got[w][bi] = miso[sel];
          if (w == 0 && b == 0) check_eq("underrun_at_start", und_cnt, f_ld[0] ? 0 : 1);
          SCK = ~cpol;
          half_wait(sel, ld_now, f_tx[w+1]);
          SCK = cpol;
        end else begin
          half_wait(sel, 1'b0, '0);
          SCK  = ~cpol;
          MOSI = f_mosi[w][bi];
          half_wait(sel, ld_now, f_tx[w+1]);
          got[w][bi] = miso[sel];
          if (w == 0 && b == 0) check_eq("underrun_at_start", und_cnt, f_ld[0] ? 0 : 1);
          SCK = cpol;
        end
      end
    end
    if (aborted) begin
      if (use_rst) begin
        #1 rst = 1'b1;
        #1;
        check_reset_vals(sel);
        SCK     = cpol;
        ss[sel] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (HALF) @(negedge clk);
        check_eq("idle_after_rst_busy", busy[sel], 0);
      end else begin
        ss[sel] = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("abort_busy", busy[sel], 0);
        check_eq("abort_oe", miso_oe[sel], 0);
        check_eq("abort_miso", miso[sel], 0);
      end
      check_eq("abort_no_valid", rxq.size(), 0);
    end else begin
      half_wait(sel, 1'b0, '0);
      ss[sel] = 1'b1;
      repeat (HALF) @(negedge clk);
      check_eq("end_busy", busy[sel], 0);
      check_eq("end_oe", miso_oe[sel], 0);
      check_eq("rx_word_count", rxq.size(), n);
      exp_und = 1;  // buffer is empty again when the last word closes
      for (int w = 0; w < n; w++) begin
        if (w < rxq.size()) check_eq("rx_word", rxq[w], f_mosi[w]);
        check_eq("master_rx_word", got[w], f_ld[w] ? f_tx[w] : '0);
        if (!f_ld[w]) exp_und++;
      end
      check_eq("underrun_count", und_cnt, exp_und);
      check_eq("data_out_last", data_out[sel], f_mosi[n-1]);
    end
    check_eq("other_instance_quiet", stray, 0);
  endtask

  initial begin
    rst        = 1'b1;
    SCK        = 1'b0;
    MOSI       = 1'b0;
    ss[0]      = 1'b1;
    ss[1]      = 1'b1;
    tx_load[0] = 1'b0;
    tx_load[1] = 1'b0;
    data_in[0] = '0;
    data_in[1] = '0;
    for (int i = 0; i < 4; i++) begin
      f_mosi[i] = '0;
      f_tx[i]   = '0;
      f_ld[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // T1
    f_mosi[0] = 8'h3C; f_tx[0] = 8'hA5; f_ld[0] = 1'b1;
    run_frame(0, 1, -1, 1'b0);
    // T2
    f_mosi[0] = 8'h12; f_tx[0] = 8'h81; f_ld[0] = 1'b1;
    run_frame(1, 1, -1, 1'b0);
    // T3
    f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
    f_tx[0]   = 8'h11; f_tx[1]   = 8'h22; f_tx[2]   = 8'h33;
    f_ld[0] = 1'b1; f_ld[1] = 1'b1; f_ld[2] = 1'b1;
    run_frame(0, 3, -1, 1'b0);
    run_frame(1, 3, -1, 1'b0);
    // T4
    f_mosi[0] = 8'h6B; f_ld[0] = 1'b0;
    run_frame(0, 1, -1, 1'b0);
    run_frame(1, 1, -1, 1'b0);
    // T5
    f_mosi[0] = 8'hE7; f_tx[0] = 8'h3C; f_ld[0] = 1'b1;
    run_frame(0, 1, 5, 1'b0);
    f_mosi[0] = 8'h5A; f_tx[0] = 8'h96;
    run_frame(0, 1, -1, 1'b0);
    // T6
    f_mosi[0] = 8'h77; f_tx[0] = 8'h99; f_ld[0] = 1'b1;
    run_frame(0, 1, 3, 1'b1);
    f_mosi[0] = 8'hC3; f_tx[0] = 8'h4E;
    run_frame(0, 1, -1, 1'b0);
    f_mosi[0] = 8'h77; f_tx[0] = 8'h99;
    run_frame(1, 1, 3, 1'b1);
    f_mosi[0] = 8'hC3; f_tx[0] = 8'h4E;
    run_frame(1, 1, -1, 1'b0);

    // Randomized frames: instance, word count, data and load pattern.
    repeat (16) begin
      int sel, n;
      sel = int'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        f_mosi[i] = W'($urandom);
        f_tx[i]   = W'($urandom);
        f_ld[i]   = ($urandom_range(0, 3) != 0);
      end
      run_frame(sel, n, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
